cac_rx_assembler: RTL

- Sits directly downstream of the 7-TSV CAC decoder on the receive side of the link.
- Collects successive decoded CAC chunks (`BLEN_07` bits each) into one wide payload word.
- Presents the assembled word on a valid/ready output, with one word of buffering so collection of the next word continues while the previous word waits.
- Detects framing errors (misplaced start-of-frame) and counts them.

---
 rtl/cac_rx_assembler.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cac_rx_assembler.sv
// rtl/cac_rx_assembler.sv - assembles decoded CAC chunks into wide words with a one-word output buffer
module cac_rx_assembler #(
    parameter  int CHUNK_W = 5,
    parameter  int NCHUNK  = 4,
    localparam int OUT_W   = CHUNK_W * NCHUNK
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic [CHUNK_W-1:0] in_chunk,
    output logic               in_ready,
    output logic               out_valid,
    output logic [OUT_W-1:0]   out_data,
    input  logic               out_ready,
    output logic               err_pulse,
    output logic [7:0]         err_count
);

    localparam int CNT_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_slot;
    logic [OUT_W-1:0]   r_acc;
    logic [OUT_W-1:0]   w_acc_nxt;
    logic [OUT_W-1:0]   w_merged;
    logic [OUT_W-1:0]   r_out_data;
    logic               r_out_valid;
    logic               r_err_pulse;
    logic [7:0]         r_err_count;
    logic               w_could_complete;
    logic               w_accept;
    logic               w_complete;
    logic               w_err;

    // Only a completing chunk needs the output register free; partial words keep flowing.
    assign w_could_complete = (NCHUNK == 1) ||
                              ((r_state == COLLECT) && (r_cnt == CNT_W'(NCHUNK - 1)));
    assign in_ready = !(r_out_valid && !out_ready && w_could_complete);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_complete  = 1'b0;
        w_err       = 1'b0;
        w_slot      = in_sof ? '0 : r_cnt;
        w_merged    = in_sof ? '0 : r_acc;
        for (int k = 0; k < NCHUNK; k++) begin
            if (k[CNT_W-1:0] == w_slot) begin
                w_merged[k*CHUNK_W +: CHUNK_W] = in_chunk;
            end
        end

        if (w_accept) begin
            if (in_sof) begin
                w_err = (r_state == COLLECT);
                if (NCHUNK == 1) begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_acc_nxt   = '0;
                end else begin
                    w_state_nxt = COLLECT;
                    w_cnt_nxt   = CNT_W'(1);
                    w_acc_nxt   = w_merged;
                end
            end else if (r_state == IDLE) begin
                w_err = 1'b1;
            end else if (r_cnt == CNT_W'(NCHUNK - 1)) begin
                w_complete  = 1'b1;
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_acc_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                w_acc_nxt = w_merged;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err_pulse <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            if (w_complete) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_merged;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_err_pulse <= w_err;
            if (w_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

endmodule
